// File: rtl/timer_pkg.sv
// Shared definitions for the serial-triggered timer: default sizing, the
// one-hot state indices of the control FSM and the delay field type.
package timer_pkg;

   localparam int DELAY_W_DEF         = 4;
   localparam int CYCLES_PER_UNIT_DEF = 1000;

   // Bit positions in the control FSM's one-hot state vector
   localparam int S     = 0;
   localparam int S1    = 1;
   localparam int S11   = 2;
   localparam int S110  = 3;
   localparam int B0    = 4;
   localparam int B1    = 5;
   localparam int B2    = 6;
   localparam int B3    = 7;
   localparam int Count = 8;
   localparam int Wait  = 9;

   typedef logic [DELAY_W_DEF-1:0] delay_t;

endpackage

// File: rtl/timer_prescaler.sv
// Divides the clock into delay units: counts CYCLES_PER_UNIT enabled cycles
// and flags the last cycle of each unit. A cycle without enable discards progress.
module timer_prescaler
   import timer_pkg::*;
#(
   parameter int CYCLES_PER_UNIT = CYCLES_PER_UNIT_DEF
) (
   input  logic clk,
   input  logic areset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CW = $clog2(CYCLES_PER_UNIT);
   localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_UNIT - 1);

   logic [CW-1:0] cyc_q;
   logic          last_s;

   assign last_s = (cyc_q == LAST);
   assign tick   = en & ~clr & last_s;

   // Cycle-within-unit counter; wraps at the end of each unit, clears when idle
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         cyc_q <= '0;
      end else if (clr || !en) begin
         cyc_q <= '0;
      end else if (last_s) begin
         cyc_q <= '0;
      end else begin
         cyc_q <= cyc_q + CW'(1);
      end
   end

endmodule

// File: rtl/timer_delay_datapath.sv
// Datapath of the serial-triggered timer: serial delay capture, unit-based
// countdown and the same-cycle done flag fed back to the control FSM.
module timer_delay_datapath
   import timer_pkg::*;
#(
   parameter int DELAY_W         = DELAY_W_DEF,
   parameter int CYCLES_PER_UNIT = CYCLES_PER_UNIT_DEF
) (
   input  logic               clk,
   input  logic               areset,
   input  logic               data,
   input  logic               shift_ena,
   input  logic               counting,
   output logic [DELAY_W-1:0] count,
   output logic               done_counting,
   output logic               overlap_err
);

   logic [DELAY_W-1:0] delay_q;
   logic               err_q;
   logic               cnt_en_s;
   logic               tick_s;

   // Shift has priority over counting, so the prescaler only runs without a shift
   assign cnt_en_s = counting & ~shift_ena;

   timer_prescaler #(
      .CYCLES_PER_UNIT(CYCLES_PER_UNIT)
   ) u_prescaler (
      .clk   (clk),
      .areset(areset),
      .clr   (shift_ena),
      .en    (cnt_en_s),
      .tick  (tick_s)
   );

   // Delay register: serial load MSB first, otherwise decrement per unit, floored at zero
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         delay_q <= '0;
      end else if (shift_ena) begin
         delay_q <= {delay_q[DELAY_W-2:0], data};
      end else if (tick_s && (delay_q != '0)) begin
         delay_q <= delay_q - DELAY_W'(1);
      end else begin
         delay_q <= delay_q;
      end
   end

   // Sticky record of the FSM asserting shift and count together
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         err_q <= 1'b0;
      end else if (shift_ena && counting) begin
         err_q <= 1'b1;
      end else begin
         err_q <= err_q;
      end
   end

   assign count         = delay_q;
   assign done_counting = tick_s & (delay_q == '0);
   assign overlap_err   = err_q;

endmodule

// File: tb/tb_timer_delay_datapath.sv
// Self-checking bench for timer_delay_datapath: a short-unit instance for the
// table-driven cases and a default-sized instance for the long countdown.
module tb_timer_delay_datapath;

   logic       clk;
   logic       areset;
   logic       data;
   logic       shift_ena;
   logic       counting;
   logic [3:0] count_a;
   logic       done_a;
   logic       err_a;
   logic [3:0] count_b;
   logic       done_b;
   logic       err_b;

   typedef struct {
      logic       d;
      logic       sh;
      logic       cn;
      logic [3:0] cnt;
      logic       done;
      logic       err;
   } vec_t;

   typedef struct {
      logic [3:0] cnt;
      logic       done;
      logic       err;
      int         sel;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_vec = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   timer_delay_datapath #(
      .DELAY_W(4),
      .CYCLES_PER_UNIT(5)
   ) u_a (
      .clk          (clk),
      .areset       (areset),
      .data         (data),
      .shift_ena    (shift_ena),
      .counting     (counting),
      .count        (count_a),
      .done_counting(done_a),
      .overlap_err  (err_a)
   );

   timer_delay_datapath #(
      .DELAY_W(4),
      .CYCLES_PER_UNIT(1000)
   ) u_b (
      .clk          (clk),
      .areset       (areset),
      .data         (data),
      .shift_ena    (shift_ena),
      .counting     (counting),
      .count        (count_b),
      .done_counting(done_b),
      .overlap_err  (err_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
      end
   endtask

   // One clock cycle: drive at the falling edge, check done before the rising
   // edge and the registered state just after it.
   task automatic step(input logic d, input logic sh, input logic cn, input int sel,
                       input logic [3:0] ecnt, input logic edone, input logic eerr);
      exp_t e;
      exp_t g;
      data      = d;
      shift_ena = sh;
      counting  = cn;
      e.cnt  = ecnt;
      e.done = edone;
      e.err  = eerr;
      e.sel  = sel;
      sb.push_back(e);
      n_vec++;
      #2;
      g = sb.pop_front();
      if (g.sel == 0) chk("done_a", n_vec, {3'b000, done_a}, {3'b000, g.done});
      else            chk("done_b", n_vec, {3'b000, done_b}, {3'b000, g.done});
      @(posedge clk);
      #1;
      if (g.sel == 0) begin
         chk("count_a", n_vec, count_a, g.cnt);
         chk("err_a", n_vec, {3'b000, err_a}, {3'b000, g.err});
      end else begin
         chk("count_b", n_vec, count_b, g.cnt);
         chk("err_b", n_vec, {3'b000, err_b}, {3'b000, g.err});
      end
      @(negedge clk);
   endtask

   task automatic add(input logic d, input logic sh, input logic cn,
                      input logic [3:0] cnt, input logic done, input logic err);
      vec_t v;
      v.d = d; v.sh = sh; v.cn = cn; v.cnt = cnt; v.done = done; v.err = err;
      tbl.push_back(v);
   endtask

   initial begin
      areset    = 1'b1;
      data      = 1'b0;
      shift_ena = 1'b0;
      counting  = 1'b0;

      // Shift 1,0,1,1 then six zeros
      add(1'b1, 1'b1, 1'b0, 4'd1,  1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 4'd2,  1'b0, 1'b0);
      add(1'b1, 1'b1, 1'b0, 4'd5,  1'b0, 1'b0);
      add(1'b1, 1'b1, 1'b0, 4'd11, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 4'd6,  1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 4'd12, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 4'd8,  1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0);
      // Delay 0, counting 12 cycles: done in cycles 5 and 10, no wrap
      for (int i = 1; i <= 12; i++)
         add(1'b0, 1'b0, 1'b1, 4'd0, (i == 5 || i == 10) ? 1'b1 : 1'b0, 1'b0);
      // Delay 1, 3 counting cycles, 1 idle, then 10 counting cycles
      add(1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) add(1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++)
         add(1'b0, 1'b0, 1'b1, (i < 5) ? 4'd1 : 4'd0, (i == 10) ? 1'b1 : 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      // Reach cyc=last with delay 0, then shift and count together
      for (int i = 1; i <= 4; i++) add(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      add(1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1);
      add(1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1);
      add(1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1);
      // Load 7 and start counting
      add(1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1);
      add(1'b1, 1'b1, 1'b0, 4'd7, 1'b0, 1'b1);
      for (int i = 1; i <= 3; i++) add(1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b1);

      // Reset values held across a clock edge
      @(posedge clk);
      #2;
      chk("reset_count", 0, count_a, 4'd0);
      chk("reset_done", 0, {3'b000, done_a}, 4'd0);
      chk("reset_err", 0, {3'b000, err_a}, 4'd0);
      @(negedge clk);
      areset = 1'b0;

      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i].d, tbl[i].sh, tbl[i].cn, 0, tbl[i].cnt, tbl[i].done, tbl[i].err);

      // Asynchronous reset mid-count with delay 7: outputs clear without an edge
      #2;
      areset = 1'b1;
      #1;
      chk("async_count", n_vec, count_a, 4'd0);
      chk("async_done", n_vec, {3'b000, done_a}, 4'd0);
      chk("async_err", n_vec, {3'b000, err_a}, 4'd0);
      chk("async_count_b", n_vec, count_b, 4'd0);
      @(negedge clk);
      areset = 1'b0;
      // After reset counting starts from delay 0
      for (int i = 1; i <= 5; i++)
         step(1'b0, 1'b0, 1'b1, 0, 4'd0, (i == 5) ? 1'b1 : 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 0, 4'd0, 1'b0, 1'b0);

      // Long unit: delay 2, 1000 cycles per unit, done only in cycle 3000
      step(1'b0, 1'b1, 1'b0, 1, 4'd0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1, 4'd0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1, 4'd1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1, 4'd2, 1'b0, 1'b0);
      for (int i = 1; i <= 3000; i++)
         step(1'b0, 1'b0, 1'b1, 1, (i < 1000) ? 4'd2 : ((i < 2000) ? 4'd1 : 4'd0),
              (i == 3000) ? 1'b1 : 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1, 4'd0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
